lsu_data_mem: RTL and testbench

- Data-memory responder for the single-cycle RV64 core. It is the memory-side end of the memWrite/memType interface that the control unit drives.
- Accepts one load or store request per handshake and performs byte/half/word/double accesses into a 64-bit-wide byte-enabled RAM.
- Splits word-crossing (misaligned) accesses into two beats.
- Returns sign- or zero-extended load data and a fault flag.

---
 rtl/lsu_data_mem_pkg.sv | 65 ++++++
 rtl/lsu_data_mem_data_ram.sv | 37 +++
 rtl/lsu_data_mem.sv | 197 +++++++++++++++++++
 tb/tb_lsu_data_mem.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_data_mem_pkg.sv
// Shared memory-type encodings, FSM states and size/extension helpers for the
// RV64 data-memory responder.
package lsu_data_mem_pkg;

   localparam int MemTypeBusBits = 3;
   localparam int Xlen           = 64;

   // memType values equal the load/store funct3 encodings
   localparam logic [MemTypeBusBits-1:0] MemTypeB    = 3'b000;
   localparam logic [MemTypeBusBits-1:0] MemTypeH    = 3'b001;
   localparam logic [MemTypeBusBits-1:0] MemTypeW    = 3'b010;
   localparam logic [MemTypeBusBits-1:0] MemTypeD    = 3'b011;
   localparam logic [MemTypeBusBits-1:0] MemTypeBU   = 3'b100;
   localparam logic [MemTypeBusBits-1:0] MemTypeHU   = 3'b101;
   localparam logic [MemTypeBusBits-1:0] MemTypeWU   = 3'b110;
   localparam logic [MemTypeBusBits-1:0] MemTypeRsvd = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BEAT0 = 2'd1,
      ST_BEAT1 = 2'd2,
      ST_RESP  = 2'd3
   } lsu_state_e;

   function automatic logic [3:0] mem_size_bytes(input logic [MemTypeBusBits-1:0] mem_type);
      logic [3:0] size;
      case (mem_type)
         MemTypeB, MemTypeBU: size = 4'd1;
         MemTypeH, MemTypeHU: size = 4'd2;
         MemTypeW, MemTypeWU: size = 4'd4;
         MemTypeD:            size = 4'd8;
         default:             size = 4'd8;
      endcase
      return size;
   endfunction

   function automatic logic [7:0] mem_byte_mask(input logic [3:0] size);
      logic [7:0] mask;
      case (size)
         4'd1:    mask = 8'h01;
         4'd2:    mask = 8'h03;
         4'd4:    mask = 8'h0F;
         default: mask = 8'hFF;
      endcase
      return mask;
   endfunction

   // truncate the LSB-aligned raw data to the access size, then extend
   function automatic logic [Xlen-1:0] mem_extend(input logic [Xlen-1:0] raw,
                                                  input logic [MemTypeBusBits-1:0] mem_type);
      logic [Xlen-1:0] ext;
      case (mem_type)
         MemTypeB:  ext = {{56{raw[7]}}, raw[7:0]};
         MemTypeH:  ext = {{48{raw[15]}}, raw[15:0]};
         MemTypeW:  ext = {{32{raw[31]}}, raw[31:0]};
         MemTypeBU: ext = {56'd0, raw[7:0]};
         MemTypeHU: ext = {48'd0, raw[15:0]};
         MemTypeWU: ext = {32'd0, raw[31:0]};
         MemTypeD:  ext = raw;
         default:   ext = 64'd0;
      endcase
      return ext;
   endfunction

endpackage

// File: rtl/lsu_data_mem_data_ram.sv
// DEPTH_WORDS x 64-bit synchronous RAM: one byte-enabled write port and one
// read port with a registered output (1-cycle read latency, read-before-write).
module data_ram #(
   parameter int DEPTH_WORDS = 1024,
   parameter int AW          = $clog2(DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic [AW-1:0] raddr,
   output logic [63:0]   rdata,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [7:0]    wbe,
   input  logic [63:0]   wdata
);

   logic [63:0] mem_r [DEPTH_WORDS];
   logic [63:0] rdata_r;

   // byte-enabled write port
   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < 8; b++) begin
            if (wbe[b]) begin
               mem_r[waddr][8*b +: 8] <= wdata[8*b +: 8];
            end
         end
      end
   end

   // registered read port
   always_ff @(posedge clk) begin
      rdata_r <= mem_r[raddr];
   end

   assign rdata = rdata_r;

endmodule

// File: rtl/lsu_data_mem.sv
// Data-memory responder for the single-cycle RV64 core: one load/store per
// handshake, misaligned accesses split into two RAM beats, extended load data.
module lsu_data_mem
   import lsu_data_mem_pkg::*;
#(
   parameter int XLEN        = 64,
   parameter int DEPTH_WORDS = 1024
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_write,
   input  logic [MemTypeBusBits-1:0] req_type,
   input  logic [XLEN-1:0]           req_addr,
   input  logic [XLEN-1:0]           req_wdata,
   output logic                      rsp_valid,
   output logic [XLEN-1:0]           rsp_rdata,
   output logic                      rsp_fault
);

   localparam int              AW       = $clog2(DEPTH_WORDS);
   localparam logic [XLEN:0]   MemBytes = (XLEN+1)'(DEPTH_WORDS) << 3;

   lsu_state_e                state_r, state_s;
   logic                      write_r;
   logic [MemTypeBusBits-1:0] type_r;
   logic [2:0]                offset_r;
   logic [AW-1:0]             word_r;
   logic                      split_r;
   logic [7:0]                be_lo_r, be_hi_r;
   logic [XLEN-1:0]           st_lo_r, st_hi_r;
   logic [XLEN-1:0]           stage_r;
   logic                      rsp_valid_r, rsp_fault_r;
   logic [XLEN-1:0]           rsp_rdata_r;

   logic                      accept_s, fault_s, split_s;
   logic [3:0]                size_s;
   logic [2:0]                offset_s;
   logic [XLEN:0]             last_s;
   logic [15:0]               mask_s;
   logic [2*XLEN-1:0]         st_shift_s;

   logic [AW-1:0]             ram_raddr_s, ram_waddr_s;
   logic [63:0]               ram_rdata_s, ram_wdata_s;
   logic [7:0]                ram_wbe_s;
   logic                      ram_we_s;
   logic [XLEN-1:0]           ld_lo_s, ld_hi_s, ld_raw_s, ld_data_s;

   assign req_ready = (state_r == ST_IDLE);
   assign rsp_valid = rsp_valid_r;
   assign rsp_rdata = rsp_rdata_r;
   assign rsp_fault = rsp_fault_r;

   // request decode: size, split, fault and pre-shifted store data at accept
   always_comb begin
      accept_s   = req_valid & (state_r == ST_IDLE);
      size_s     = mem_size_bytes(req_type);
      offset_s   = req_addr[2:0];
      split_s    = (({1'b0, offset_s} + size_s) > 4'd8);
      last_s     = {1'b0, req_addr} + {{(XLEN-3){1'b0}}, size_s} - {{XLEN{1'b0}}, 1'b1};
      fault_s    = (req_type == MemTypeRsvd) | (req_write & req_type[2]) | (last_s >= MemBytes);
      mask_s     = {8'h00, mem_byte_mask(size_s)} << offset_s;
      st_shift_s = {{XLEN{1'b0}}, req_wdata} << {offset_s, 3'b000};
   end

   // next-state logic
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               state_s = fault_s ? ST_RESP : ST_BEAT0;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_BEAT0: state_s = split_r ? ST_BEAT1 : ST_RESP;
         ST_BEAT1: state_s = ST_RESP;
         ST_RESP:  state_s = ST_IDLE;
         default:  state_s = ST_IDLE;
      endcase
   end

   // RAM port steering; word A is read at the accept edge so it is ready in BEAT0
   always_comb begin
      ram_raddr_s = word_r + AW'(1);
      ram_we_s    = 1'b0;
      ram_waddr_s = word_r;
      ram_wbe_s   = be_lo_r;
      ram_wdata_s = st_lo_r;
      if (state_r == ST_IDLE) begin
         ram_raddr_s = req_addr[3 +: AW];
      end else begin
         ram_raddr_s = word_r + AW'(1);
      end
      if (state_r == ST_BEAT1) begin
         ram_we_s    = write_r;
         ram_waddr_s = word_r + AW'(1);
         ram_wbe_s   = be_hi_r;
         ram_wdata_s = st_hi_r;
      end else begin
         ram_we_s    = write_r & (state_r == ST_BEAT0);
         ram_waddr_s = word_r;
         ram_wbe_s   = be_lo_r;
         ram_wdata_s = st_lo_r;
      end
   end

   // load assembly: {beat1, beat0} shifted down by the byte offset, then extended
   always_comb begin
      ld_lo_s = ram_rdata_s;
      ld_hi_s = {XLEN{1'b0}};
      if (state_r == ST_BEAT1) begin
         ld_lo_s = stage_r;
         ld_hi_s = ram_rdata_s;
      end else begin
         ld_lo_s = ram_rdata_s;
         ld_hi_s = {XLEN{1'b0}};
      end
      ld_raw_s  = XLEN'({ld_hi_s, ld_lo_s} >> {offset_r, 3'b000});
      ld_data_s = write_r ? {XLEN{1'b0}} : mem_extend(ld_raw_s, type_r);
   end

   // state, request capture and registered response
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         write_r     <= 1'b0;
         type_r      <= MemTypeB;
         offset_r    <= 3'd0;
         word_r      <= {AW{1'b0}};
         split_r     <= 1'b0;
         be_lo_r     <= 8'h00;
         be_hi_r     <= 8'h00;
         st_lo_r     <= {XLEN{1'b0}};
         st_hi_r     <= {XLEN{1'b0}};
         stage_r     <= {XLEN{1'b0}};
         rsp_valid_r <= 1'b0;
         rsp_fault_r <= 1'b0;
         rsp_rdata_r <= {XLEN{1'b0}};
      end else begin
         state_r     <= state_s;
         rsp_valid_r <= (state_s == ST_RESP);
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  write_r  <= req_write;
                  type_r   <= req_type;
                  offset_r <= offset_s;
                  word_r   <= req_addr[3 +: AW];
                  split_r  <= split_s;
                  be_lo_r  <= mask_s[7:0];
                  be_hi_r  <= mask_s[15:8];
                  st_lo_r  <= st_shift_s[XLEN-1:0];
                  st_hi_r  <= st_shift_s[2*XLEN-1:XLEN];
                  if (fault_s) begin
                     rsp_fault_r <= 1'b1;
                     rsp_rdata_r <= {XLEN{1'b0}};
                  end
               end
            end
            ST_BEAT0: begin
               stage_r <= ram_rdata_s;
               if (!split_r) begin
                  rsp_fault_r <= 1'b0;
                  rsp_rdata_r <= ld_data_s;
               end
            end
            ST_BEAT1: begin
               rsp_fault_r <= 1'b0;
               rsp_rdata_r <= ld_data_s;
            end
            ST_RESP: begin
               stage_r <= stage_r;
            end
            default: begin
               stage_r <= stage_r;
            end
         endcase
      end
   end

   data_ram #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_data_ram (
      .clk   (clk),
      .raddr (ram_raddr_s),
      .rdata (ram_rdata_s),
      .we    (ram_we_s),
      .waddr (ram_waddr_s),
      .wbe   (ram_wbe_s),
      .wdata (ram_wdata_s)
   );

endmodule

// File: tb/tb_lsu_data_mem.sv
// Scoreboard bench for lsu_data_mem: stimulus pushes hand-computed responses
// (data, fault, arrival cycle); a negedge monitor pops and compares them.
module tb_lsu_data_mem;

   localparam logic [2:0] T_B = 3'b000, T_H = 3'b001, T_W = 3'b010, T_D = 3'b011;
   localparam logic [2:0] T_BU = 3'b100, T_HU = 3'b101, T_WU = 3'b110, T_RSV = 3'b111;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [2:0]  req_type = 3'b000;
   logic [63:0] req_addr = 64'd0;
   logic [63:0] req_wdata = 64'd0;
   logic        rsp_valid;
   logic [63:0] rsp_rdata;
   logic        rsp_fault;

   typedef struct {
      logic [63:0] rdata;
      logic        fault;
      int          cyc;
      int          id;
   } exp_t;

   exp_t sb_q[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   int   n_acc = 0;
   int   n_issued = 0;

   lsu_data_mem #(.XLEN(64), .DEPTH_WORDS(1024)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_type  (req_type),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_fault (rsp_fault)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string nm, input int id, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (req %0d): got 0x%016h, expected 0x%016h", nm, id, act, exp);
      end
   endfunction

   // monitor: count accepts, pop and compare every response
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (req_valid && req_ready) n_acc++;
         if (rsp_valid) begin
            if (sb_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_rsp: got rsp_valid=1 (rdata 0x%016h), expected none", rsp_rdata);
            end else begin
               e = sb_q.pop_front();
               chk("rdata", e.id, rsp_rdata, e.rdata);
               chk("fault", e.id, {63'd0, rsp_fault}, {63'd0, e.fault});
               chk("latency_cycle", e.id, 64'(cyc), 64'(e.cyc));
               chk("ready_low_in_resp", e.id, {63'd0, req_ready}, 64'd0);
            end
         end
      end
   end

   task automatic issue(input bit wr, input logic [2:0] ty, input logic [63:0] addr, input logic [63:0] wd,
                        input int lat, input bit flt, input logic [63:0] rd, input bit keep, input bit expect_rsp);
      int   waited = 0;
      int   acc = 0;
      logic rdy = 1'b0;
      exp_t e;
      req_valid = 1'b1;
      req_write = wr;
      req_type  = ty;
      req_addr  = addr;
      req_wdata = wd;
      do begin
         rdy = req_ready;
         acc = cyc;
         @(posedge clk);
         #1;
         waited++;
      end while (!rdy && waited < 100);
      if (!rdy) begin
         n_checks++;
         n_fail++;
         $display("FAIL accept_timeout: got no accept in %0d cycles, expected accept", waited);
      end else begin
         n_issued++;
         if (expect_rsp) begin
            e.rdata = rd;
            e.fault = flt;
            e.cyc   = acc + lat;
            e.id    = n_issued;
            sb_q.push_back(e);
         end
      end
      if (!keep) req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int t = 0;
      while (sb_q.size() != 0 && t < 50) begin
         @(posedge clk);
         #1;
         t++;
      end
      if (sb_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL rsp_timeout: got %0d responses outstanding, expected 0", sb_q.size());
         sb_q.delete();
      end
      @(posedge clk);
      #1;
   endtask

   task automatic ld(input logic [2:0] ty, input logic [63:0] addr, input int lat, input bit flt, input logic [63:0] rd);
      issue(1'b0, ty, addr, 64'd0, lat, flt, rd, 1'b0, 1'b1);
      wait_idle();
   endtask

   task automatic st(input logic [2:0] ty, input logic [63:0] addr, input logic [63:0] wd, input int lat, input bit flt);
      issue(1'b1, ty, addr, wd, lat, flt, 64'd0, 1'b0, 1'b1);
      wait_idle();
   endtask

   initial begin
      #3;
      chk("reset_rsp_valid", 0, {63'd0, rsp_valid}, 64'd0);
      chk("reset_rsp_fault", 0, {63'd0, rsp_fault}, 64'd0);
      chk("reset_rsp_rdata", 0, rsp_rdata, 64'd0);
      chk("reset_req_ready", 0, {63'd0, req_ready}, 64'd1);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;

      // doubleword stores and loads
      st(T_D, 64'h10, 64'h1122334455667788, 2, 1'b0);
      st(T_D, 64'h18, 64'h0123456789ABCDEF, 2, 1'b0);
      st(T_D, 64'h20, 64'h8877665544332211, 2, 1'b0);
      ld(T_D, 64'h10, 2, 1'b0, 64'h1122334455667788);
      ld(T_B, 64'h17, 2, 1'b0, 64'h11);
      // extension
      ld(T_B,  64'h10, 2, 1'b0, 64'hFFFFFFFFFFFFFF88);
      ld(T_BU, 64'h10, 2, 1'b0, 64'h88);
      ld(T_H,  64'h16, 2, 1'b0, 64'h1122);
      ld(T_HU, 64'h10, 2, 1'b0, 64'h7788);
      // misaligned split store; upper wdata bits must be ignored
      st(T_W, 64'h1E, 64'hDEADBEEFAABBCCDD, 3, 1'b0);
      ld(T_W,  64'h1E, 3, 1'b0, 64'hFFFFFFFFAABBCCDD);
      ld(T_WU, 64'h1E, 3, 1'b0, 64'hAABBCCDD);
      ld(T_BU, 64'h20, 2, 1'b0, 64'hBB);
      ld(T_BU, 64'h21, 2, 1'b0, 64'hAA);
      ld(T_BU, 64'h22, 2, 1'b0, 64'h33);
      ld(T_BU, 64'h1D, 2, 1'b0, 64'h45);
      ld(T_D,  64'h18, 2, 1'b0, 64'hCCDD456789ABCDEF);
      ld(T_WU, 64'h1C, 2, 1'b0, 64'hCCDD4567);
      ld(T_H,  64'h17, 3, 1'b0, 64'hFFFFFFFFFFFFEF11);
      ld(T_HU, 64'h1F, 3, 1'b0, 64'hBBCC);
      // faults and end-of-memory boundary
      ld(T_RSV, 64'h10, 1, 1'b1, 64'd0);
      st(T_D, 64'h1FF8, 64'h0F1E2D3C4B5A6978, 2, 1'b0);
      ld(T_D, 64'h1FFC, 1, 1'b1, 64'd0);
      st(T_D, 64'h1FFC, 64'hFFFFFFFFFFFFFFFF, 1, 1'b1);
      ld(T_D, 64'h1FF8, 2, 1'b0, 64'h0F1E2D3C4B5A6978);
      ld(T_B, 64'h1FFF, 2, 1'b0, 64'h0F);
      ld(T_B, 64'h2000, 1, 1'b1, 64'd0);
      st(T_BU, 64'h10, 64'hEE, 1, 1'b1);
      ld(T_D, 64'h10, 2, 1'b0, 64'h1122334455667788);

      // req_valid held high: back-to-back requests in order
      issue(1'b0, T_D,   64'h10, 64'd0, 2, 1'b0, 64'h1122334455667788, 1'b1, 1'b1);
      issue(1'b0, T_BU,  64'h20, 64'd0, 2, 1'b0, 64'hBB, 1'b1, 1'b1);
      issue(1'b0, T_W,   64'h1E, 64'd0, 3, 1'b0, 64'hFFFFFFFFAABBCCDD, 1'b1, 1'b1);
      issue(1'b0, T_RSV, 64'h10, 64'd0, 1, 1'b1, 64'd0, 1'b1, 1'b1);
      issue(1'b0, T_HU,  64'h10, 64'd0, 2, 1'b0, 64'h7788, 1'b0, 1'b1);
      wait_idle();

      // reset during BEAT1 of a split load
      ld(T_D, 64'h10, 2, 1'b0, 64'h1122334455667788);
      issue(1'b0, T_W, 64'h1E, 64'd0, 3, 1'b0, 64'd0, 1'b0, 1'b0);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("midop_rst_rsp_valid", 0, {63'd0, rsp_valid}, 64'd0);
      chk("midop_rst_rsp_rdata", 0, rsp_rdata, 64'd0);
      chk("midop_rst_rsp_fault", 0, {63'd0, rsp_fault}, 64'd0);
      chk("midop_rst_req_ready", 0, {63'd0, req_ready}, 64'd1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      ld(T_D, 64'h18, 2, 1'b0, 64'hCCDD456789ABCDEF);

      chk("accept_count", 0, 64'(n_acc), 64'(n_issued));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
